// File: rtl/voice_scheduler.sv
// Four-voice note scheduler: allocates voices to note events and fetches the
// wavetable for a voice only when its cached program differs from the request.
module voice_scheduler #(
  parameter int LOAD_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_on,
  input  logic [6:0]  ev_note,
  input  logic [6:0]  ev_program,
  output logic        wtb_load,
  output logic [4:0]  wtb_num,
  output logic [1:0]  voice_num,
  input  logic        wtb_load_done,
  input  logic [4:0]  wtb_load_num,
  output logic [3:0]  voice_gate,
  output logic [27:0] voice_note,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, ALLOC, LOAD_REQ, LOAD_WAIT, COMMIT} state_t;

  localparam logic [11:0] TMO_LAST = 12'(LOAD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [6:0]  note_q;
  logic [4:0]  prog_q;
  logic [3:0]  loaded_valid;
  logic [4:0]  loaded_wtb [4];
  logic [1:0]  steal_ptr;
  logic [11:0] tmo_cnt;

  logic        accept, done_ok, tmo_hit;
  logic        off_hit, rtg_hit, free_hit, alloc_steal, cache_hit;
  logic [1:0]  off_v, rtg_v, free_v, alloc_v;

  assign accept  = ev_valid && ev_ready;
  assign done_ok = (state == LOAD_WAIT) && wtb_load_done && (wtb_load_num == wtb_num);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Descending scans so the lowest matching voice wins.
  always_comb begin
    off_hit  = 1'b0;
    off_v    = 2'd0;
    rtg_hit  = 1'b0;
    rtg_v    = 2'd0;
    free_hit = 1'b0;
    free_v   = 2'd0;
    for (int v = 3; v >= 0; v--) begin
      if (voice_gate[v] && (voice_note[7*v +: 7] == ev_note)) begin
        off_hit = 1'b1;
        off_v   = 2'(v);
      end
      if (voice_gate[v] && (voice_note[7*v +: 7] == note_q)) begin
        rtg_hit = 1'b1;
        rtg_v   = 2'(v);
      end
      if (!voice_gate[v]) begin
        free_hit = 1'b1;
        free_v   = 2'(v);
      end
    end
    alloc_steal = !rtg_hit && !free_hit;
    alloc_v     = rtg_hit ? rtg_v : (free_hit ? free_v : steal_ptr);
    cache_hit   = loaded_valid[alloc_v] && (loaded_wtb[alloc_v] == prog_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept && ev_on) state_nxt = ALLOC;
      ALLOC:     state_nxt = cache_hit ? COMMIT : LOAD_REQ;
      LOAD_REQ:  state_nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        if (done_ok)      state_nxt = COMMIT;
        else if (tmo_hit) state_nxt = IDLE;
      end
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Handshake is withheld during reset so nothing is taken while rst is high.
  always_comb begin
    ev_ready = (state == IDLE) && !rst;
    wtb_load = (state == LOAD_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      voice_gate   <= '0;
      voice_note   <= '0;
      loaded_valid <= '0;
      for (int v = 0; v < 4; v++) loaded_wtb[v] <= '0;
      steal_ptr    <= '0;
      wtb_num      <= '0;
      voice_num    <= '0;
      tmo_cnt      <= '0;
      load_err     <= 1'b0;
    end else begin
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && ev_on) begin
            note_q <= ev_note;
            prog_q <= ev_program[4:0];
          end else if (accept && off_hit) begin
            voice_gate[off_v] <= 1'b0;
          end
        end
        ALLOC: begin
          voice_gate[alloc_v] <= 1'b0;
          voice_num           <= alloc_v;
          wtb_num             <= prog_q;
          if (alloc_steal) steal_ptr <= steal_ptr + 2'd1;
        end
        LOAD_REQ: begin
          loaded_valid[voice_num] <= 1'b0;
          tmo_cnt                 <= '0;
        end
        LOAD_WAIT: begin
          if (!done_ok) begin
            if (tmo_hit) load_err <= 1'b1;
            else         tmo_cnt  <= tmo_cnt + 12'd1;
          end
        end
        COMMIT: begin
          voice_note[7*voice_num +: 7] <= note_q;
          voice_gate[voice_num]        <= 1'b1;
          loaded_valid[voice_num]      <= 1'b1;
          loaded_wtb[voice_num]        <= wtb_num;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, wavetable caching, stealing,
// timeout and reset behaviour with hand-computed expectations.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid, ev_ready, ev_on;
  logic [6:0]  ev_note, ev_program;
  logic        wtb_load;
  logic [4:0]  wtb_num;
  logic [1:0]  voice_num;
  logic        wtb_load_done;
  logic [4:0]  wtb_load_num;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_scheduler dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_program(ev_program), .wtb_load(wtb_load), .wtb_num(wtb_num),
    .voice_num(voice_num), .wtb_load_done(wtb_load_done), .wtb_load_num(wtb_load_num),
    .voice_gate(voice_gate), .voice_note(voice_note), .load_err(load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one event and returns one cycle after the transfer (cycle T+1).
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] prog);
    int n = 0;
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_program = prog;
    while (ev_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (ev_ready !== 1'b1) begin
      $display("FAIL send_ready: ev_ready=%b after %0d cycles, required 1", ev_ready, n);
      errors++;
    end
    tick();
    ev_valid = 1'b0;
  endtask

  // Note-on carried through to the cycle the gate becomes visible.
  task automatic play(input logic [6:0] note, input logic [6:0] prog, output logic loaded);
    send(1'b1, note, prog);
    tick();
    loaded = wtb_load;
    if (loaded) begin
      tick();
      wtb_load_done = 1'b1; wtb_load_num = prog[4:0];
      tick();
      wtb_load_done = 1'b0;
      tick();
    end else begin
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({voice_gate, voice_note, wtb_num, voice_num, wtb_load, load_err} !== '0) begin
      $display("FAIL reset_outputs: gate=%b note=%h wtb_num=%0d voice_num=%0d load=%b err=%b, required all 0",
               voice_gate, voice_note, wtb_num, voice_num, wtb_load, load_err);
      errors++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ev_ready !== 1'b1) begin
      $display("FAIL reset_ready: ev_ready=%b, required 1", ev_ready);
      errors++;
    end
  endtask

  task automatic test_cold_miss();
    send(1'b1, 7'd60, 7'd3);
    checks++;
    if (wtb_load !== 1'b0) begin
      $display("FAIL cold_load_early: wtb_load=%b at T+1, required 0", wtb_load); errors++;
    end
    tick();
    checks++;
    if (wtb_load !== 1'b1 || wtb_num !== 5'd3 || voice_num !== 2'd0) begin
      $display("FAIL cold_load_req: load=%b wtb_num=%0d voice_num=%0d, required 1/3/0",
               wtb_load, wtb_num, voice_num); errors++;
    end
    tick();
    checks++;
    if (wtb_load !== 1'b0) begin
      $display("FAIL cold_load_pulse: wtb_load=%b at T+3, required 0", wtb_load); errors++;
    end
    tick();
    wtb_load_done = 1'b1; wtb_load_num = 5'd3;
    tick();
    wtb_load_done = 1'b0;
    checks++;
    if (voice_gate !== 4'b0000) begin
      $display("FAIL cold_gate_d1: gate=%b at D+1, required 0000", voice_gate); errors++;
    end
    tick();
    checks++;
    if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd60) begin
      $display("FAIL cold_commit: gate=%b note0=%0d, required 0001/60", voice_gate, voice_note[6:0]);
      errors++;
    end
  endtask

  task automatic test_cache_hit();
    send(1'b0, 7'd60, 7'd0);
    checks++;
    if (voice_gate !== 4'b0000) begin
      $display("FAIL hit_noteoff: gate=%b, required 0000", voice_gate); errors++;
    end
    send(1'b1, 7'd64, 7'd3);
    tick();
    checks++;
    if (wtb_load !== 1'b0 || voice_gate !== 4'b0000) begin
      $display("FAIL hit_t2: load=%b gate=%b, required 0/0000", wtb_load, voice_gate); errors++;
    end
    tick();
    checks++;
    if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd64) begin
      $display("FAIL hit_t3: gate=%b note0=%0d, required 0001/64", voice_gate, voice_note[6:0]);
      errors++;
    end
  endtask

  task automatic test_steal();
    logic ld;
    play(7'd65, 7'd3, ld);
    play(7'd66, 7'd3, ld);
    play(7'd67, 7'd3, ld);
    checks++;
    if (voice_gate !== 4'b1111 || voice_note !== {7'd67, 7'd66, 7'd65, 7'd64}) begin
      $display("FAIL steal_fill: gate=%b notes=%h, required 1111/%h", voice_gate, voice_note,
               {7'd67, 7'd66, 7'd65, 7'd64}); errors++;
    end
    play(7'd70, 7'd3, ld);
    checks++;
    if (ld !== 1'b0 || voice_num !== 2'd0 || voice_note[6:0] !== 7'd70 || voice_gate !== 4'b1111) begin
      $display("FAIL steal_fifth: load=%b voice=%0d note0=%0d gate=%b, required 0/0/70/1111",
               ld, voice_num, voice_note[6:0], voice_gate); errors++;
    end
    play(7'd71, 7'd3, ld);
    checks++;
    if (ld !== 1'b0 || voice_num !== 2'd1 || voice_note[13:7] !== 7'd71) begin
      $display("FAIL steal_sixth: load=%b voice=%0d note1=%0d, required 0/1/71",
               ld, voice_num, voice_note[13:7]); errors++;
    end
  endtask

  task automatic test_note_off();
    send(1'b0, 7'd50, 7'd0);
    checks++;
    if (voice_gate !== 4'b1111 || voice_note !== {7'd67, 7'd66, 7'd71, 7'd70}) begin
      $display("FAIL off_unplayed: gate=%b notes=%h, required 1111/%h", voice_gate, voice_note,
               {7'd67, 7'd66, 7'd71, 7'd70}); errors++;
    end
    send(1'b0, 7'd66, 7'd0);
    checks++;
    if (voice_gate !== 4'b1011 || voice_note !== {7'd67, 7'd66, 7'd71, 7'd70}) begin
      $display("FAIL off_played: gate=%b notes=%h, required 1011/%h", voice_gate, voice_note,
               {7'd67, 7'd66, 7'd71, 7'd70}); errors++;
    end
  endtask

  task automatic test_retrigger();
    logic ld;
    play(7'd71, 7'd3, ld);
    checks++;
    if (ld !== 1'b0 || voice_num !== 2'd1 || voice_gate !== 4'b1011) begin
      $display("FAIL retrig: load=%b voice=%0d gate=%b, required 0/1/1011", ld, voice_num, voice_gate);
      errors++;
    end
    play(7'd80, 7'd3, ld);
    checks++;
    if (ld !== 1'b0 || voice_num !== 2'd2 || voice_gate !== 4'b1111 || voice_note[20:14] !== 7'd80) begin
      $display("FAIL free_pick: load=%b voice=%0d gate=%b note2=%0d, required 0/2/1111/80",
               ld, voice_num, voice_gate, voice_note[20:14]); errors++;
    end
  endtask

  task automatic test_timeout();
    int n;
    send(1'b1, 7'd90, 7'd5);
    tick();
    checks++;
    if (wtb_load !== 1'b1 || wtb_num !== 5'd5 || voice_num !== 2'd2) begin
      $display("FAIL tmo_req: load=%b wtb_num=%0d voice=%0d, required 1/5/2", wtb_load, wtb_num, voice_num);
      errors++;
    end
    tick();
    wtb_load_done = 1'b1; wtb_load_num = 5'd7;
    tick();
    wtb_load_done = 1'b0;
    checks++;
    if (voice_gate !== 4'b1011 || load_err !== 1'b0) begin
      $display("FAIL tmo_wrong_done: gate=%b err=%b, required 1011/0", voice_gate, load_err); errors++;
    end
    n = 1;
    while (load_err !== 1'b1 && n < 5000) begin tick(); n++; end
    checks++;
    if (n != 4095) begin
      $display("FAIL tmo_latency: load_err after %0d cycles, required 4095", n); errors++;
    end
    checks++;
    if (ev_ready !== 1'b1 || voice_gate !== 4'b1011) begin
      $display("FAIL tmo_abort: ready=%b gate=%b, required 1/1011", ev_ready, voice_gate); errors++;
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      $display("FAIL tmo_pulse: load_err=%b, required 0", load_err); errors++;
    end
    // Reload on the freed voice; a done pulse outside LOAD_WAIT must not commit.
    send(1'b1, 7'd90, 7'd5);
    wtb_load_done = 1'b1; wtb_load_num = 5'd5;
    tick();
    checks++;
    if (wtb_load !== 1'b1 || voice_num !== 2'd2 || wtb_num !== 5'd5) begin
      $display("FAIL reload_req: load=%b voice=%0d wtb_num=%0d, required 1/2/5", wtb_load, voice_num, wtb_num);
      errors++;
    end
    tick();
    wtb_load_done = 1'b0;
    tick();
    tick();
    checks++;
    if (voice_gate !== 4'b1011) begin
      $display("FAIL done_outside_wait: gate=%b, required 1011", voice_gate); errors++;
    end
    wtb_load_done = 1'b1;
    tick();
    wtb_load_done = 1'b0;
    tick();
    checks++;
    if (voice_gate !== 4'b1111 || voice_note[20:14] !== 7'd90) begin
      $display("FAIL reload_commit: gate=%b note2=%0d, required 1111/90", voice_gate, voice_note[20:14]);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_program = 7'd3;
    checks++;
    if (ev_ready !== 1'b1) begin
      $display("FAIL b2b_ready0: ready=%b, required 1", ev_ready); errors++;
    end
    tick();
    ev_note = 7'd61;
    checks++;
    if (ev_ready !== 1'b0) begin
      $display("FAIL b2b_busy: ready=%b in ALLOC, required 0", ev_ready); errors++;
    end
    tick();
    tick();
    checks++;
    if (ev_ready !== 1'b1 || voice_gate !== 4'b1111 || voice_note[27:21] !== 7'd60 || voice_num !== 2'd3) begin
      $display("FAIL b2b_first: ready=%b gate=%b note3=%0d voice=%0d, required 1/1111/60/3",
               ev_ready, voice_gate, voice_note[27:21], voice_num); errors++;
    end
    tick();
    ev_valid = 1'b0;
    tick();
    checks++;
    if (voice_gate !== 4'b1110) begin
      $display("FAIL b2b_alloc: gate=%b, required 1110", voice_gate); errors++;
    end
    tick();
    checks++;
    if (voice_gate !== 4'b1111 || voice_note[6:0] !== 7'd61 || voice_num !== 2'd0) begin
      $display("FAIL b2b_second: gate=%b note0=%0d voice=%0d, required 1111/61/0",
               voice_gate, voice_note[6:0], voice_num); errors++;
    end
  endtask

  task automatic test_reset_mid_load();
    send(1'b1, 7'd100, 7'd12);
    tick();
    checks++;
    if (wtb_load !== 1'b1 || voice_num !== 2'd1 || wtb_num !== 5'd12) begin
      $display("FAIL rml_req: load=%b voice=%0d wtb_num=%0d, required 1/1/12", wtb_load, voice_num, wtb_num);
      errors++;
    end
    tick();
    rst = 1'b1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd5; ev_program = 7'd3;
    tick();
    checks++;
    if ({voice_gate, voice_note, wtb_num, voice_num, wtb_load, load_err} !== '0) begin
      $display("FAIL rml_outputs: gate=%b note=%h wtb_num=%0d voice=%0d load=%b err=%b, required all 0",
               voice_gate, voice_note, wtb_num, voice_num, wtb_load, load_err); errors++;
    end
    tick();
    rst = 1'b0;
    ev_valid = 1'b0;
    tick();
    checks++;
    if (ev_ready !== 1'b1 || voice_gate !== 4'b0000 || wtb_load !== 1'b0) begin
      $display("FAIL rml_after: ready=%b gate=%b load=%b, required 1/0000/0", ev_ready, voice_gate, wtb_load);
      errors++;
    end
    send(1'b1, 7'd60, 7'd3);
    tick();
    checks++;
    if (wtb_load !== 1'b1 || voice_num !== 2'd0 || wtb_num !== 5'd3) begin
      $display("FAIL rml_cache_cleared: load=%b voice=%0d wtb_num=%0d, required 1/0/3",
               wtb_load, voice_num, wtb_num); errors++;
    end
    tick();
    wtb_load_done = 1'b1; wtb_load_num = 5'd3;
    tick();
    wtb_load_done = 1'b0;
    tick();
    checks++;
    if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd60) begin
      $display("FAIL rml_replay: gate=%b note0=%0d, required 0001/60", voice_gate, voice_note[6:0]);
      errors++;
    end
  endtask

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_program = '0;
    wtb_load_done = 1'b0; wtb_load_num = '0;
    test_reset();
    test_cold_miss();
    test_cache_hit();
    test_steal();
    test_note_off();
    test_retrigger();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
